// File: rtl/fifo_status_monitor.sv
// Status/interrupt monitor for NUM_CH FIFOs: registers each FIFO's status signals,
// keeps sticky overflow/underflow flags and fill-level watermarks, and serves register reads.
module fifo_status_monitor #(
    parameter int NUM_CH      = 4,
    parameter int USEDW_WIDTH = 8,
    parameter int AFULL_LVL   = 2**USEDW_WIDTH - 4,
    parameter int AEMPTY_LVL  = 4
) (
    input  logic                          clk,
    input  logic                          rstx,
    input  logic [NUM_CH*USEDW_WIDTH-1:0] usedw,
    input  logic [NUM_CH-1:0]             full,
    input  logic [NUM_CH-1:0]             empty,
    input  logic [NUM_CH-1:0]             wrreq,
    input  logic [NUM_CH-1:0]             rdreq,
    input  logic                          rd_en,
    input  logic [3:0]                    rd_sel,
    input  logic                          rd_word,
    input  logic [NUM_CH-1:0]             irq_mask,
    output logic [31:0]                   status,
    output logic                          status_valid,
    output logic                          irq
);

    localparam int W = USEDW_WIDTH;
    localparam logic [W-1:0] AFULL_T  = W'(AFULL_LVL);
    localparam logic [W-1:0] AEMPTY_T = W'(AEMPTY_LVL);

    // Input stage
    logic [NUM_CH*W-1:0] usedw_q;
    logic [NUM_CH-1:0]   full_q, empty_q, wrreq_q, rdreq_q, irq_mask_q;

    // Sticky flags, watermarks and read-port registers
    logic [NUM_CH-1:0]   ovf_q, ovf_d, udf_q, udf_d;
    logic [NUM_CH*W-1:0] wm_q, wm_d;
    logic [31:0]         status_q, status_d;
    logic                status_valid_q;
    logic                irq_q, irq_d;

    logic [NUM_CH-1:0]   sel_hit;
    logic [NUM_CH-1:0]   clr_hit;
    logic [NUM_CH-1:0]   afull, aempty;

    // Read port: rd_en is a one-cycle request with no back-pressure; every request
    // is answered by exactly one status_valid pulse on the following cycle, and
    // status holds its value between responses.
    always_comb begin
        sel_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_hit[c] = rd_en && (rd_sel == 4'(c));
        end
    end

    assign clr_hit = sel_hit & {NUM_CH{~rd_word}};

    always_comb begin
        afull  = '0;
        aempty = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            afull[c]  = (usedw_q[c*W +: W] >= AFULL_T) || full_q[c];
            aempty[c] = (usedw_q[c*W +: W] <= AEMPTY_T) && !full_q[c];
        end
    end

    // A new event in the same cycle as a clear-on-read keeps the flag set.
    assign ovf_d = (ovf_q & ~clr_hit) | (wrreq_q & full_q);
    assign udf_d = (udf_q & ~clr_hit) | (rdreq_q & empty_q);

    always_comb begin
        wm_d = wm_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sel_hit[c] && rd_word) begin
                wm_d[c*W +: W] = usedw_q[c*W +: W];
            end else if (usedw_q[c*W +: W] > wm_q[c*W +: W]) begin
                wm_d[c*W +: W] = usedw_q[c*W +: W];
            end
        end
    end

    // Out-of-range rd_sel matches no channel, so it returns zero and changes nothing.
    always_comb begin
        status_d = status_q;
        if (rd_en) begin
            status_d = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (sel_hit[c]) begin
                    if (rd_word) begin
                        status_d[W-1:0] = wm_q[c*W +: W];
                    end else begin
                        status_d[W-1:0] = usedw_q[c*W +: W];
                        status_d[16]    = full_q[c];
                        status_d[17]    = empty_q[c];
                        status_d[18]    = afull[c];
                        status_d[19]    = aempty[c];
                        status_d[20]    = ovf_q[c];
                        status_d[21]    = udf_q[c];
                    end
                end
            end
        end
    end

    assign irq_d = |((ovf_q | udf_q) & irq_mask_q);

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            usedw_q        <= '0;
            full_q         <= '0;
            empty_q        <= '1;
            wrreq_q        <= '0;
            rdreq_q        <= '0;
            irq_mask_q     <= '0;
            ovf_q          <= '0;
            udf_q          <= '0;
            wm_q           <= '0;
            status_q       <= '0;
            status_valid_q <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            usedw_q        <= usedw;
            full_q         <= full;
            empty_q        <= empty;
            wrreq_q        <= wrreq;
            rdreq_q        <= rdreq;
            irq_mask_q     <= irq_mask;
            ovf_q          <= ovf_d;
            udf_q          <= udf_d;
            wm_q           <= wm_d;
            status_q       <= status_d;
            status_valid_q <= rd_en;
            irq_q          <= irq_d;
        end
    end

    assign status       = status_q;
    assign status_valid = status_valid_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Self-checking bench for fifo_status_monitor (default parameters, 4 channels).
module tb_fifo_status_monitor;

    localparam int NCH    = 4;
    localparam int AFULL  = 2**8 - 4;
    localparam int AEMPTY = 4;

    logic        clk = 1'b0;
    logic        rstx = 1'b0;
    logic [7:0]  drv_usedw [NCH];
    logic [31:0] usedw;
    logic [3:0]  full, empty, wrreq, rdreq, irq_mask;
    logic        rd_en, rd_word;
    logic [3:0]  rd_sel;
    logic [31:0] status;
    logic        status_valid, irq;
    logic [31:0] d;

    int errors = 0;
    int checks = 0;

    assign usedw = {drv_usedw[3], drv_usedw[2], drv_usedw[1], drv_usedw[0]};

    fifo_status_monitor dut (
        .clk          (clk),
        .rstx         (rstx),
        .usedw        (usedw),
        .full         (full),
        .empty        (empty),
        .wrreq        (wrreq),
        .rdreq        (rdreq),
        .rd_en        (rd_en),
        .rd_sel       (rd_sel),
        .rd_word      (rd_word),
        .irq_mask     (irq_mask),
        .status       (status),
        .status_valid (status_valid),
        .irq          (irq)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // behavioural model: what the monitor has seen (one cycle late) and what it must report
    int       m_usedw [NCH];
    int       m_wm [NCH];
    bit [3:0] m_full, m_empty, m_wr, m_rd, m_mask, m_ovf, m_udf;
    bit [31:0] m_status;
    bit       m_valid, m_irq;

    function automatic logic [31:0] word0(int ch);
        logic [31:0] w;
        w = 32'(m_usedw[ch]);
        if (m_full[ch])                                 w += 32'h0001_0000;
        if (m_empty[ch])                                w += 32'h0002_0000;
        if (m_usedw[ch] >= AFULL || m_full[ch])         w += 32'h0004_0000;
        if (m_usedw[ch] <= AEMPTY && !m_full[ch])       w += 32'h0008_0000;
        if (m_ovf[ch])                                  w += 32'h0010_0000;
        if (m_udf[ch])                                  w += 32'h0020_0000;
        return w;
    endfunction

    task automatic model_step();
        logic [31:0] nxt;
        bit          any;
        bit          hit;
        int          ch;
        if (!rstx) begin
            for (int c = 0; c < NCH; c++) begin
                m_usedw[c] = 0;
                m_wm[c]    = 0;
            end
            m_full = '0; m_empty = '1; m_wr = '0; m_rd = '0; m_mask = '0;
            m_ovf = '0; m_udf = '0;
            m_status = '0; m_valid = 1'b0; m_irq = 1'b0;
        end else begin
            ch  = int'(rd_sel);
            any = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if ((m_ovf[c] || m_udf[c]) && m_mask[c]) any = 1'b1;
            end
            nxt = m_status;
            if (rd_en) begin
                if (ch >= NCH)    nxt = '0;
                else if (rd_word) nxt = 32'(m_wm[ch]);
                else              nxt = word0(ch);
            end
            for (int c = 0; c < NCH; c++) begin
                hit = rd_en && (ch == c);
                m_ovf[c] = (m_wr[c] && m_full[c])  || (m_ovf[c] && !(hit && !rd_word));
                m_udf[c] = (m_rd[c] && m_empty[c]) || (m_udf[c] && !(hit && !rd_word));
                if (hit && rd_word)         m_wm[c] = m_usedw[c];
                else if (m_usedw[c] > m_wm[c]) m_wm[c] = m_usedw[c];
            end
            m_status = nxt;
            m_valid  = rd_en;
            m_irq    = any;
            for (int c = 0; c < NCH; c++) m_usedw[c] = int'(drv_usedw[c]);
            m_full = full; m_empty = empty; m_wr = wrreq; m_rd = rdreq; m_mask = irq_mask;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rstx);
        model_step();
    end

    // compare process: every output, every cycle, half a period after the active edge
    initial forever begin
        @(negedge clk);
        chk("cyc_status", status, m_status);
        chk("cyc_valid", 32'(status_valid), 32'(m_valid));
        chk("cyc_irq", 32'(irq), 32'(m_irq));
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input logic [3:0] sel, input logic word, output logic [31:0] data);
        rd_en   = 1'b1;
        rd_sel  = sel;
        rd_word = word;
        @(negedge clk);
        rd_en = 1'b0;
        chk("rd_valid", 32'(status_valid), 32'd1);
        data = status;
    endtask

    int          thr_val [6] = '{252, 251, 4, 5, 0, 255};
    logic [31:0] thr_exp [6] = '{32'h0004_00FC, 32'h0000_00FB, 32'h0008_0004,
                                 32'h0000_0005, 32'h0008_0000, 32'h0004_00FF};

    initial begin
        for (int c = 0; c < NCH; c++) drv_usedw[c] = 8'd0;
        full = '0; empty = '1; wrreq = '0; rdreq = '0; irq_mask = '0;
        rd_en = 1'b0; rd_sel = '0; rd_word = 1'b0;
        step(2);
        chk("rst_status", status, 32'd0);
        chk("rst_valid", 32'(status_valid), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rstx  = 1'b1;
        empty = '0;
        step(2);

        // level readout
        drv_usedw[2] = 8'h5A;
        step(2);
        do_read(4'd2, 1'b0, d);
        chk("lvl_ch2", d, 32'h0000_005A);

        // overflow sticky and interrupt
        irq_mask = 4'b0010; full[1] = 1'b1; wrreq[1] = 1'b1;
        step(1);
        full[1] = 1'b0; wrreq[1] = 1'b0;
        step(1);
        chk("ovf_irq_early", 32'(irq), 32'd0);
        step(1);
        chk("ovf_irq_on", 32'(irq), 32'd1);
        do_read(4'd1, 1'b0, d);
        chk("ovf_word", d, 32'h0018_0000);
        chk("ovf_irq_hold", 32'(irq), 32'd1);
        step(1);
        chk("ovf_irq_off", 32'(irq), 32'd0);
        do_read(4'd1, 1'b0, d);
        chk("ovf_cleared", d, 32'h0008_0000);

        // underflow event collides with clear-on-read
        rdreq[0] = 1'b1; empty[0] = 1'b1;
        step(1);
        rdreq[0] = 1'b0;
        do_read(4'd0, 1'b0, d);
        chk("col_pre_clear", 32'(d[21]), 32'd0);
        do_read(4'd0, 1'b0, d);
        chk("col_kept", 32'(d[21]), 32'd1);
        do_read(4'd0, 1'b0, d);
        chk("col_cleared", 32'(d[21]), 32'd0);
        empty[0] = 1'b0;

        // watermark peak and reload
        drv_usedw[3] = 8'd200;
        step(2);
        drv_usedw[3] = 8'd50;
        step(2);
        do_read(4'd3, 1'b1, d);
        chk("wm_peak", d, 32'd200);
        do_read(4'd3, 1'b1, d);
        chk("wm_reload", d, 32'd50);

        // almost-full / almost-empty thresholds
        for (int i = 0; i < 6; i++) begin
            drv_usedw[2] = 8'(thr_val[i]);
            step(1);
            do_read(4'd2, 1'b0, d);
            chk($sformatf("thr_%0d", thr_val[i]), d, thr_exp[i]);
        end
        drv_usedw[2] = 8'd10; full[2] = 1'b1;
        step(1);
        do_read(4'd2, 1'b0, d);
        chk("thr_full", d, 32'h0005_000A);
        full[2] = 1'b0;
        do_read(4'd2, 1'b1, d);
        chk("wm_ch2", d, 32'h0000_00FF);

        // out-of-range channel, back to back
        do_read(4'd7, 1'b0, d);
        chk("oor_sel7", d, 32'd0);
        do_read(4'd15, 1'b1, d);
        chk("oor_sel15", d, 32'd0);

        // reset asserted while a read is pending
        irq_mask = 4'b0001; rdreq[0] = 1'b1; empty[0] = 1'b1;
        step(1);
        rdreq[0] = 1'b0; empty[0] = 1'b0;
        step(2);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        rd_en = 1'b1; rd_sel = 4'd2; rd_word = 1'b0;
        #2 rstx = 1'b0;
        @(negedge clk);
        rd_en = 1'b0;
        chk("rst_mid_valid", 32'(status_valid), 32'd0);
        chk("rst_mid_status", status, 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        step(1);
        rstx = 1'b1;
        step(2);
        chk("post_rst_irq", 32'(irq), 32'd0);
        do_read(4'd0, 1'b0, d);
        chk("post_rst_ch0", d, 32'h0008_0000);

        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_status_monitor.md
FIFO_STATUS_MONITOR -- requirements
Module: fifo_status_monitor

Interface
REQ-001 SHALL have the following parameters:
- NUM_CH, default 4: number of monitored FIFO channels, range 1..16.
- USEDW_WIDTH, default 8: width of each channel's usedw, range 1..15.
- AFULL_LVL, default 2**USEDW_WIDTH-4: almost-full threshold.
- AEMPTY_LVL, default 4: almost-empty threshold.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rstx  in  1  asynchronous, active-low reset.
- usedw  in  NUM_CH*USEDW_WIDTH  per-channel fill level; channel c occupies bits [c*USEDW_WIDTH +: USEDW_WIDTH].
- full  in  NUM_CH  per-channel FIFO full.
- empty  in  NUM_CH  per-channel FIFO empty.
- wrreq  in  NUM_CH  per-channel FIFO write request.
- rdreq  in  NUM_CH  per-channel FIFO read request.
- rd_en  in  1  status read request, one-cycle strobe.
- rd_sel  in  4  channel index for the read.
- rd_word  in  1  word select: 0 = status word, 1 = watermark word.
- irq_mask  in  NUM_CH  per-channel interrupt enable.
- status  out  32  read data.
- status_valid  out  1  read data valid, one-cycle pulse.
- irq  out  1  level interrupt.

Function
REQ-003 SHALL register all inputs except rd_en, rd_sel and rd_word in one input stage before any flag logic (1-cycle input latency).
REQ-004 SHALL set a channel's sticky overflow flag the cycle after registered wrreq=1 and full=1 are seen together.
REQ-005 SHALL set a channel's sticky underflow flag the cycle after registered rdreq=1 and empty=1 are seen together.
REQ-006 SHALL keep a per-channel high watermark register holding the maximum registered usedw seen; it SHALL be updated when registered usedw > watermark.
REQ-007 SHALL raise almost-full when registered usedw >= AFULL_LVL or full=1, and almost-empty when registered usedw <= AEMPTY_LVL and full=0; both flags are combinational from the input stage.
REQ-008 SHALL drive status_valid high exactly one cycle after rd_en=1 and SHALL update status in that same cycle (1-cycle read latency); rd_en may be asserted on back-to-back cycles, giving one response per request.
REQ-009 SHALL format the status word (rd_word=0) as follows:
- [USEDW_WIDTH-1:0] registered usedw; remaining bits up to 15 zero.
- [16] full, [17] empty, [18] almost-full, [19] almost-empty.
- [20] sticky overflow, [21] sticky underflow.
- [31:22] zero.
REQ-010 SHALL format the watermark word (rd_word=1) as: [USEDW_WIDTH-1:0] watermark, all other bits zero.
REQ-011 SHALL clear both sticky flags of channel rd_sel when rd_word=0 is read (clear-on-read); the returned word SHALL carry the pre-clear flag values.
REQ-012 SHALL reload the watermark of channel rd_sel with the current registered usedw when rd_word=1 is read; the returned word SHALL carry the pre-reload value.
REQ-013 SHALL give a new overflow/underflow event priority over a clear-on-read in the same cycle: the flag SHALL remain 1.
REQ-014 SHALL treat rd_sel >= NUM_CH as a valid read: status=0 and status_valid=1, with no state change.
REQ-015 SHALL drive irq, registered, as the OR over channels of (overflow|underflow) & irq_mask; irq SHALL fall the cycle after the last unmasked flag clears.
REQ-016 SHALL leave status unchanged (hold the last value) while status_valid=0.

Reset
REQ-017 SHALL, while rstx=0, force status=0, status_valid=0, irq=0, all sticky flags=0, all watermarks=0 and the input stage to 0 (empty stage=all 1s).
REQ-018 SHALL, when rstx asserts mid-read, suppress the pending status_valid; the first rising edge after rstx deasserts SHALL behave as cycle 0.

Verification
REQ-019 Level readout: ch2 usedw=8'h5A, full=0, empty=0, steady; rd_en, rd_sel=2, rd_word=0 -> next cycle status=32'h0000_005A, status_valid=1.
REQ-020 Overflow sticky plus irq: ch1 full=1, wrreq=1 for 1 cycle, irq_mask=4'b0010 -> irq=1 two cycles later; read ch1 word 0 -> bit20=1; irq=0 one cycle after the response; a second read -> bit20=0.
REQ-021 Event/clear collision: ch0 rdreq=1 and empty=1 registered in the same cycle as a clear-on-read of ch0 -> the following read still shows bit21=1.
REQ-022 Watermark: ch3 usedw ramps 0->200->50; read word 1 -> 200; the next read of word 1 -> 50.
REQ-023 Thresholds at defaults: usedw=252 -> bit18=1; usedw=4 -> bit19=1; usedw=5 -> bit19=0.
REQ-024 Reset and boundary cases:
- rstx pulsed low during a pending read -> status_valid never pulses, all outputs 0.
- rd_sel=7 with NUM_CH=4 -> status=0, status_valid=1.
